// File: rtl/axil_crossbar_rd_return.sv
// rtl/axil_crossbar_rd_return.sv - AXI4-lite crossbar read-response return stage
module axil_crossbar_rd_return #(
    parameter int M_COUNT         = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int FIFO_ADDR_WIDTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [$clog2(M_COUNT)-1:0]    s_rc_select,
    input  logic                          s_rc_decerr,
    input  logic                          s_rc_valid,
    output logic                          s_rc_ready,
    input  logic [M_COUNT*DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [M_COUNT*2-1:0]          m_axil_rresp,
    input  logic [M_COUNT-1:0]            m_axil_rvalid,
    output logic [M_COUNT-1:0]            m_axil_rready,
    output logic [DATA_WIDTH-1:0]         s_axil_rdata,
    output logic [1:0]                    s_axil_rresp,
    output logic                          s_axil_rvalid,
    input  logic                          s_axil_rready
);
    localparam int SEL_W = $clog2(M_COUNT);
    localparam int PTR_W = FIFO_ADDR_WIDTH + 1;
    localparam int DEPTH = 2 ** FIFO_ADDR_WIDTH;

    logic [SEL_W-1:0]      sel_mem_q [DEPTH];
    logic                  dec_mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  rvalid_q, rvalid_d;
    logic                  full, empty, push, pop, slot_free;
    logic [SEL_W-1:0]      head_sel;
    logic                  head_dec;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full       = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {FIFO_ADDR_WIDTH{1'b0}}};
    assign empty      = wr_ptr_q == rd_ptr_q;
    assign s_rc_ready = !full;
    assign push       = s_rc_valid && !full;
    assign slot_free  = !rvalid_q || s_axil_rready;
    assign head_sel   = sel_mem_q[rd_ptr_q[FIFO_ADDR_WIDTH-1:0]];
    assign head_dec   = dec_mem_q[rd_ptr_q[FIFO_ADDR_WIDTH-1:0]];

    assign s_axil_rdata  = rdata_q;
    assign s_axil_rresp  = rresp_q;
    assign s_axil_rvalid = rvalid_q;

    always_comb begin
        m_axil_rready = '0;
        pop           = 1'b0;
        rdata_d       = rdata_q;
        rresp_d       = rresp_q;
        rvalid_d      = rvalid_q && !s_axil_rready;
        if (!empty && slot_free) begin
            if (head_dec) begin
                pop      = 1'b1;
                rdata_d  = '0;
                rresp_d  = 2'b11;
                rvalid_d = 1'b1;
            end else begin
                // Ready is offered to the head's master only; other masters' valids are ignored.
                for (int i = 0; i < M_COUNT; i++) begin
                    if (head_sel == SEL_W'(i)) begin
                        m_axil_rready[i] = 1'b1;
                        if (m_axil_rvalid[i]) begin
                            pop      = 1'b1;
                            rdata_d  = m_axil_rdata[i*DATA_WIDTH +: DATA_WIDTH];
                            rresp_d  = m_axil_rresp[i*2 +: 2];
                            rvalid_d = 1'b1;
                        end
                    end
                end
            end
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + PTR_W'(push) - PTR_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            sel_mem_q[wr_ptr_q[FIFO_ADDR_WIDTH-1:0]] <= s_rc_select;
            dec_mem_q[wr_ptr_q[FIFO_ADDR_WIDTH-1:0]] <= s_rc_decerr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
            rresp_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Occupancy must always agree with the pointer distance.
    assert property (@(posedge clk) disable iff (rst) count_q == PTR_W'(wr_ptr_q - rd_ptr_q));

endmodule

// File: tb/tb_axil_crossbar_rd_return.sv
// tb/tb_axil_crossbar_rd_return.sv - randomized self-checking bench for axil_crossbar_rd_return
module tb_axil_crossbar_rd_return;
    localparam int M     = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int MB    = 1024;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      s_rc_select = '0;
    logic            s_rc_decerr = 1'b0;
    logic            s_rc_valid = 1'b0;
    logic            s_rc_ready;
    logic [M*DW-1:0] m_axil_rdata = '0;
    logic [M*2-1:0]  m_axil_rresp = '0;
    logic [M-1:0]    m_axil_rvalid = '0;
    logic [M-1:0]    m_axil_rready;
    logic [DW-1:0]   s_axil_rdata;
    logic [1:0]      s_axil_rresp;
    logic            s_axil_rvalid;
    logic            s_axil_rready = 1'b0;

    axil_crossbar_rd_return #(.M_COUNT(M), .DATA_WIDTH(DW), .FIFO_ADDR_WIDTH(2)) dut (
        .clk(clk), .rst(rst),
        .s_rc_select(s_rc_select), .s_rc_decerr(s_rc_decerr),
        .s_rc_valid(s_rc_valid), .s_rc_ready(s_rc_ready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
        .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready)
    );

    always #5 clk = ~clk;

    int          n_vec = 0, n_miss = 0;
    int          p_cmd = 0, p_rdy = 100, p_mst = 0;
    logic [3:0]  mst_en = 4'hF;
    logic        cmd_v = 1'b0;
    logic [1:0]  cmd_sel = '0;
    logic        cmd_dec = 1'b0;
    logic [33:0] next_beat;
    logic [33:0] mbeat [M][MB];
    int          mwr [M];
    int          mrd [M];
    logic [M-1:0] mhs = '0;
    logic [33:0] exp_q [$];
    int          pend_q [$];
    int          accepted = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [33:0] rnd_beat();
        return {$urandom(), 2'($urandom_range(3))};
    endfunction

    // One clock: drive at the falling edge, then evaluate what the next rising edge will do.
    task automatic cycle();
        logic [33:0] e;
        @(negedge clk);
        s_axil_rready = int'($urandom_range(99)) < p_rdy;
        if (!cmd_v && int'($urandom_range(99)) < p_cmd) begin
            cmd_v   = 1'b1;
            cmd_sel = 2'($urandom_range(3));
            cmd_dec = $urandom_range(3) == 0;
        end
        s_rc_valid  = cmd_v;
        s_rc_select = cmd_sel;
        s_rc_decerr = cmd_dec;
        for (int i = 0; i < M; i++) begin
            if (mhs[i]) m_axil_rvalid[i] = 1'b0;
            if (!m_axil_rvalid[i] && mrd[i] < mwr[i] && mst_en[i] && int'($urandom_range(99)) < p_mst) begin
                m_axil_rvalid[i]          = 1'b1;
                m_axil_rdata[i*DW +: DW]  = mbeat[i][mrd[i] % MB][33:2];
                m_axil_rresp[i*2 +: 2]    = mbeat[i][mrd[i] % MB][1:0];
            end
        end
        mhs = '0;
        #1;
        if (s_axil_rvalid && s_axil_rready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 64'(s_axil_rvalid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rdata", 64'(s_axil_rdata), 64'(e[33:2]));
                chk("rresp", 64'(s_axil_rresp), 64'(e[1:0]));
            end
        end
        if (m_axil_rready != '0)
            chk("rready_head", 64'(m_axil_rready), (pend_q.size() > 0) ? (64'd1 << pend_q[0]) : 64'd0);
        for (int i = 0; i < M; i++) begin
            if (m_axil_rvalid[i] && m_axil_rready[i]) begin
                mhs[i] = 1'b1;
                mrd[i]++;
                if (pend_q.size() > 0) void'(pend_q.pop_front());
            end
        end
        if (s_rc_valid && s_rc_ready) begin
            accepted++;
            cmd_v = 1'b0;
            if (cmd_dec) begin
                exp_q.push_back({32'h0, 2'b11});
            end else begin
                mbeat[cmd_sel][mwr[cmd_sel] % MB] = next_beat;
                mwr[cmd_sel]++;
                exp_q.push_back(next_beat);
                pend_q.push_back(int'(cmd_sel));
            end
            next_beat = rnd_beat();
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        p_cmd = 0; p_rdy = 100; p_mst = 100; mst_en = 4'hF;
        while ((exp_q.size() != 0 || cmd_v) && n < 300) begin
            cycle();
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic scen_basic();
        p_cmd = 0; p_mst = 0; p_rdy = 100;
        next_beat = {32'hDEADBEEF, 2'b00};
        cmd_v = 1'b1; cmd_sel = 2'd2; cmd_dec = 1'b0;
        cycle();
        cycle();
        chk("basic_rready", 64'(m_axil_rready), 64'b0100);
        chk("basic_rvalid_lo", 64'(s_axil_rvalid), 64'd0);
        p_mst = 100;
        cycle();
        chk("basic_mhs", 64'(m_axil_rvalid & m_axil_rready), 64'b0100);
        p_mst = 0;
        cycle();
        chk("basic_rvalid", 64'(s_axil_rvalid), 64'd1);
        chk("basic_rdata", 64'(s_axil_rdata), 64'hDEADBEEF);
        chk("basic_rresp", 64'(s_axil_rresp), 64'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rc_ready"}, 64'(s_rc_ready), 64'd1);
        chk({tag, "_rvalid"}, 64'(s_axil_rvalid), 64'd0);
        chk({tag, "_rdata"}, 64'(s_axil_rdata), 64'd0);
        chk({tag, "_rresp"}, 64'(s_axil_rresp), 64'd0);
        chk({tag, "_m_rready"}, 64'(m_axil_rready), 64'd0);
    endtask

    initial begin
        next_beat = rnd_beat();
        repeat (3) @(posedge clk);
        chk_reset_vals("in_reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reset_vals("after_reset");

        scen_basic();

        // Decode error: generated locally, no master readied.
        p_mst = 0;
        cmd_v = 1'b1; cmd_sel = 2'd1; cmd_dec = 1'b1;
        cycle();
        cycle();
        chk("dec_rvalid_n1", 64'(s_axil_rvalid), 64'd0);
        chk("dec_m_rready", 64'(m_axil_rready), 64'd0);
        cycle();
        chk("dec_rvalid_n2", 64'(s_axil_rvalid), 64'd1);
        chk("dec_rdata", 64'(s_axil_rdata), 64'd0);
        chk("dec_rresp", 64'(s_axil_rresp), 64'd3);
        chk("dec_m_rready2", 64'(m_axil_rready), 64'd0);

        // Ordering: master 1 answers early but waits behind master 3.
        p_mst = 100; mst_en = 4'b0010;
        cmd_v = 1'b1; cmd_sel = 2'd3; cmd_dec = 1'b0;
        cycle();
        cmd_v = 1'b1; cmd_sel = 2'd1; cmd_dec = 1'b0;
        cycle();
        repeat (3) cycle();
        chk("order_rready", 64'(m_axil_rready), 64'b1000);
        chk("order_m1_valid", 64'(m_axil_rvalid), 64'b0010);
        drain();

        // Back-pressure until full, then release.
        accepted = 0;
        p_rdy = 0; p_mst = 100; p_cmd = 100;
        repeat (12) cycle();
        chk("full_accepts", 64'(accepted), 64'(DEPTH + 1));
        chk("full_ready", 64'(s_rc_ready), 64'd0);
        chk("full_rvalid", 64'(s_axil_rvalid), 64'd1);
        p_cmd = 0; p_rdy = 100;
        cycle();
        cycle();
        chk("ready_back", 64'(s_rc_ready), 64'd1);
        chk("stream_1", 64'(s_axil_rvalid), 64'd1);
        for (int k = 2; k <= 4; k++) begin
            cycle();
            chk("stream_n", 64'(s_axil_rvalid), 64'd1);
        end
        drain();

        // Random traffic across many pointer wraps.
        p_cmd = 50; p_rdy = 70; p_mst = 60; mst_en = 4'hF;
        repeat (600) cycle();
        drain();

        // Reset with commands queued and a response held at the output.
        accepted = 0;
        p_rdy = 0; p_mst = 100; p_cmd = 100;
        for (int n = 0; n < 20 && accepted < 4; n++) cycle();
        p_cmd = 0;
        cycle();
        chk("pre_rst_rvalid", 64'(s_axil_rvalid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        exp_q.delete();
        pend_q.delete();
        cmd_v = 1'b0; s_rc_valid = 1'b0; m_axil_rvalid = '0; mhs = '0;
        for (int i = 0; i < M; i++) begin
            mwr[i] = 0;
            mrd[i] = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reset_vals("rerelease");
        scen_basic();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

endmodule
